// File: rtl/fetch_sequencer.sv
// Fetch-stage pipeline controller: boot redirect, load-use stalls, branch redirects,
// halt drain/pause and end-of-program detection, plus a saturating stall counter.
module fetch_sequencer #(
   parameter logic [63:0] RESET_PC     = 64'h0,
   parameter int          BOOT_CYCLES  = 2,
   parameter int          DRAIN_CYCLES = 3,
   parameter logic [63:0] END_PC       = 64'h168
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [63:0] pc,
   input  logic [4:0]  id_rs1,
   input  logic [4:0]  id_rs2,
   input  logic        id_uses_rs1,
   input  logic        id_uses_rs2,
   input  logic        ex_mem_read,
   input  logic [4:0]  ex_rd,
   input  logic        ex_branch_taken,
   input  logic [63:0] ex_branch_target,
   input  logic        halt_req,
   output logic        branch_en,
   output logic [63:0] branch_pc,
   output logic        stall,
   output logic        flush_ifid,
   output logic        flush_idex,
   output logic        halt_ack,
   output logic        done,
   output logic [31:0] stall_count
);

   typedef enum logic [2:0] {
      BOOT     = 3'd0,
      REDIRECT = 3'd1,
      RUN      = 3'd2,
      DRAIN    = 3'd3,
      HALTED   = 3'd4,
      DONE     = 3'd5
   } state_t;

   localparam logic [3:0] BOOT_LAST  = 4'(BOOT_CYCLES - 1);
   localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        drain_end_q, drain_end_d;
   logic [31:0] stall_cnt_q;
   logic        load_use;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   // x0 is never a real dependency, so a load to it cannot cause a hazard
   assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                     ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                      (id_uses_rs2 && (id_rs2 == ex_rd)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= BOOT;
         cnt_q       <= 4'd0;
         drain_end_q <= 1'b0;
         stall_cnt_q <= 32'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         drain_end_q <= drain_end_d;
         if (stall) stall_cnt_q <= sat_inc(stall_cnt_q);
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      drain_end_d = drain_end_q;
      branch_en   = 1'b0;
      branch_pc   = 64'd0;
      stall       = 1'b0;
      flush_ifid  = 1'b0;
      flush_idex  = 1'b0;
      unique case (state_q)
         BOOT: begin
            stall = 1'b1;
            if (cnt_q == BOOT_LAST) begin
               state_d = REDIRECT;
               cnt_d   = 4'd0;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         REDIRECT: begin
            branch_en  = 1'b1;
            branch_pc  = RESET_PC;
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
            state_d    = RUN;
         end
         RUN: begin
            if (ex_branch_taken) begin
               branch_en  = 1'b1;
               branch_pc  = ex_branch_target;
               flush_ifid = 1'b1;
               flush_idex = 1'b1;
            end else if (load_use) begin
               stall      = 1'b1;
               flush_idex = 1'b1;
            end
            if (pc == END_PC) begin
               state_d     = DRAIN;
               drain_end_d = 1'b1;
               cnt_d       = 4'd0;
            end else if (halt_req) begin
               state_d     = DRAIN;
               drain_end_d = 1'b0;
               cnt_d       = 4'd0;
            end
         end
         DRAIN: begin
            stall      = 1'b1;
            flush_ifid = 1'b1;
            // a late taken branch refills fetch, so the drain must start over
            if (ex_branch_taken) begin
               branch_en  = 1'b1;
               branch_pc  = ex_branch_target;
               flush_idex = 1'b1;
               cnt_d      = 4'd0;
            end else if (cnt_q == DRAIN_LAST) begin
               state_d = drain_end_q ? DONE : HALTED;
               cnt_d   = 4'd0;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         HALTED: begin
            stall = 1'b1;
            if (!halt_req) state_d = RUN;
         end
         DONE: begin
            stall = 1'b1;
         end
         default: begin
            stall   = 1'b1;
            state_d = BOOT;
            cnt_d   = 4'd0;
         end
      endcase
   end

   assign halt_ack    = (state_q == HALTED);
   assign done        = (state_q == DONE);
   assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: directed per-cycle vectors push expected
// control outputs; a negedge monitor pops and compares them.
module tb_fetch_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [63:0] pc;
   logic [4:0]  id_rs1, id_rs2, ex_rd;
   logic        id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken, halt_req;
   logic [63:0] ex_branch_target;
   logic        branch_en, stall, flush_ifid, flush_idex, halt_ack, done;
   logic [63:0] branch_pc;
   logic [31:0] stall_count;

   typedef struct {
      string        name;
      logic [102:0] vec;
   } exp_t;

   exp_t        sb[$];
   int          tests = 0;
   int          fails = 0;
   logic [31:0] model_sc = 32'd0;

   always #5 clk = ~clk;

   fetch_sequencer dut (
      .clk(clk), .rst_n(rst_n), .pc(pc),
      .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
      .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
      .ex_branch_taken(ex_branch_taken), .ex_branch_target(ex_branch_target),
      .halt_req(halt_req),
      .branch_en(branch_en), .branch_pc(branch_pc), .stall(stall),
      .flush_ifid(flush_ifid), .flush_idex(flush_idex),
      .halt_ack(halt_ack), .done(done), .stall_count(stall_count)
   );

   // monitor: every falling edge, compare live outputs against the oldest expectation
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t         e;
         logic [102:0] act;
         e   = sb.pop_front();
         act = {branch_en, branch_pc, stall, flush_ifid, flush_idex, halt_ack, done, stall_count};
         tests++;
         if (act !== e.vec) begin
            fails++;
            $display("FAIL %s: got be=%0b bpc=%h st=%0b fi=%0b fx=%0b ha=%0b dn=%0b sc=%h, expected vec=%h",
                     e.name, branch_en, branch_pc, stall, flush_ifid, flush_idex,
                     halt_ack, done, stall_count, e.vec);
         end
      end
   end

   task automatic step(input string nm, input logic be, input logic [63:0] bpc,
                       input logic st, input logic fi, input logic fx,
                       input logic ha, input logic dn);
      exp_t e;
      e.name = nm;
      e.vec  = {be, bpc, st, fi, fx, ha, dn, model_sc};
      sb.push_back(e);
      if (rst_n && st && model_sc != 32'hFFFF_FFFF) model_sc = model_sc + 32'd1;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      pc = 64'd0; id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
      id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_mem_read = 1'b0;
      ex_branch_taken = 1'b0; ex_branch_target = 64'd0; halt_req = 1'b0;
   endtask

   task automatic boot_seq();
      step("boot0",    1'b0, 64'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step("boot1",    1'b0, 64'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step("redirect", 1'b1, 64'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      step("run0",     1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      idle_inputs();
      @(posedge clk); #1;
      step("reset_state", 1'b0, 64'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;
      boot_seq();

      // load-use via rs2
      ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
      step("lu_rs2", 1'b0, 64'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      idle_inputs();
      step("lu_after", 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs2 = 5'd0; id_uses_rs2 = 1'b1;
      step("lu_x0", 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      ex_rd = 5'd7; id_rs1 = 5'd7; id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b0;
      step("lu_rs1", 1'b0, 64'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      id_uses_rs1 = 1'b0;
      step("lu_unused", 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // taken branch beats a simultaneous load-use
      id_uses_rs1 = 1'b1; ex_branch_taken = 1'b1; ex_branch_target = 64'h58;
      step("br_over_lu", 1'b1, 64'h58, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      idle_inputs();

      // plain halt
      halt_req = 1'b1;
      step("halt_req",  1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step("drain0",    1'b0, 64'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      step("drain1",    1'b0, 64'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      step("drain2",    1'b0, 64'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      step("halted0",   1'b0, 64'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      step("halted1",   1'b0, 64'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      halt_req = 1'b0;
      step("halt_rel",  1'b0, 64'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      step("resume",    1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // halt with a branch on drain cycle 2; halt_req drops mid-drain
      halt_req = 1'b1;
      step("halt2_req", 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step("d2_0",      1'b0, 64'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      ex_branch_taken = 1'b1; ex_branch_target = 64'h100;
      step("d2_branch", 1'b1, 64'h100, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      ex_branch_taken = 1'b0; ex_branch_target = 64'd0;
      step("d2_r0",     1'b0, 64'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      halt_req = 1'b0;
      step("d2_r1",     1'b0, 64'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      step("d2_r2",     1'b0, 64'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      step("halted_1c", 1'b0, 64'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      step("resume2",   1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // end of program wins over a simultaneous halt
      pc = 64'h168; halt_req = 1'b1;
      step("end_pc",    1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      pc = 64'h16c;
      step("e_drain0",  1'b0, 64'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      step("e_drain1",  1'b0, 64'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      step("e_drain2",  1'b0, 64'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      step("done0",     1'b0, 64'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      halt_req = 1'b0;
      step("done1",     1'b0, 64'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      halt_req = 1'b1;
      step("done_halt", 1'b0, 64'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      idle_inputs();

      // asynchronous reset from DONE
      rst_n = 1'b0; model_sc = 32'd0;
      #1;
      step("rst_pulse", 1'b0, 64'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;
      boot_seq();

      // saturation of the stall counter with stall held by a load-use
      ex_mem_read = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3; id_uses_rs1 = 1'b1;
      force dut.stall_cnt_q = 32'hFFFF_FFFE;
      #1;
      release dut.stall_cnt_q;
      model_sc = 32'hFFFF_FFFE;
      step("sat_fffe",  1'b0, 64'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      step("sat_ffff",  1'b0, 64'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      step("sat_hold",  1'b0, 64'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      idle_inputs();

      for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
      if (sb.size() > 0) begin
         fails++;
         tests++;
         $display("FAIL drain_scoreboard: %0d entries left, required 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Controller that sequences the fetch stage of the five-stage pipeline: drives the fetch stage's `branch_en`, `branch_pc` and `stall` inputs and the IF/ID and ID/EX flush controls. It handles the post-reset boot redirect, load-use stalls, taken-branch redirects, external halt requests and end-of-program detection. It sits between the decode/execute stages and the fetch stage and holds the only pipeline-control state machine in the core.

## Interface
- `RESET_PC`, 64'h0: address fetch is redirected to at the end of boot.
- `BOOT_CYCLES`, 2: cycles fetch is held stalled after reset release; legal range 1–15.
- `DRAIN_CYCLES`, 3: bubble cycles inserted before a halt or end is acknowledged; legal range 1–15.
- `END_PC`, 64'h168: fetch PC value that marks end of program.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `pc` in 64: current fetch-stage PC.
- `id_rs1`, `id_rs2` in 5 each: source registers of the instruction in ID.
- `id_uses_rs1`, `id_uses_rs2` in 1 each: the ID instruction reads that source.
- `ex_mem_read` in 1: the EX instruction is a load.
- `ex_rd` in 5: destination register of the EX instruction.
- `ex_branch_taken` in 1: the EX instruction resolved as a taken branch or jump.
- `ex_branch_target` in 64: target address of that branch.
- `halt_req` in 1: level request to pause the pipeline.
- `branch_en` out 1: to fetch; load `branch_pc` into PC.
- `branch_pc` out 64: redirect address.
- `stall` out 1: to fetch; hold PC.
- `flush_ifid` out 1: turn the IF/ID register into a bubble.
- `flush_idex` out 1: turn the ID/EX register into a bubble.
- `halt_ack` out 1: the pipeline is drained and paused.
- `done` out 1: end of program reached.
- `stall_count` out 32: saturating count of cycles with `stall`=1.

## Operation
- States: BOOT, REDIRECT, RUN, DRAIN, HALTED, DONE. A 4-bit counter `cnt` is shared by BOOT and DRAIN. A 1-bit `drain_end` flag records whether a drain was started by end-of-program (1) or by halt (0).
- BOOT: `stall`=1. `cnt` counts up from 0. When `cnt`=`BOOT_CYCLES`-1, go to REDIRECT.
- REDIRECT, one cycle: `branch_en`=1, `branch_pc`=`RESET_PC`, `flush_ifid`=`flush_idex`=1. Then go to RUN.
- RUN, evaluated in priority order each cycle:
  1. `ex_branch_taken`=1: `branch_en`=1, `branch_pc`=`ex_branch_target`, `flush_ifid`=`flush_idex`=1. Stay in RUN. A load-use condition in the same cycle is ignored.
  2. Load-use: `ex_mem_read` && `ex_rd`!=0 && ((`id_uses_rs1` && `id_rs1`==`ex_rd`) || (`id_uses_rs2` && `id_rs2`==`ex_rd`)). Drive `stall`=1 and `flush_idex`=1 for that cycle only.
  3. Otherwise all controls are 0.
  - Transitions out of RUN (independent of items 1–3 above):
    - `pc`==`END_PC`: go to DRAIN, `drain_end`=1, `cnt`=0.
    - else `halt_req`=1: go to DRAIN, `drain_end`=0, `cnt`=0.
    - End takes priority over halt.
- DRAIN: `stall`=1 and `flush_ifid`=1 every cycle. A taken branch during DRAIN is still honoured: `branch_en`=1, `flush_idex`=1, and `cnt` restarts at 0. When `cnt`=`DRAIN_CYCLES`-1, go to DONE if `drain_end`=1, else HALTED.
- HALTED: `stall`=1, `halt_ack`=1. When `halt_req`=0, go to RUN.
- DONE: `stall`=1, `done`=1. Only reset leaves DONE.
- `branch_pc` is 0 whenever `branch_en`=0.
- `stall_count` increments on every cycle where `stall`=1 and saturates at 32'hFFFF_FFFF.

## Timing
- State, `cnt`, `drain_end` and `stall_count` are registered. `branch_en`, `branch_pc`, `stall` and both flushes are combinational from state and current inputs, so they respond in zero cycles.
- `halt_ack` and `done` are decoded from the registered state.
- Reset values: state BOOT, `cnt`=0, `drain_end`=0, `stall_count`=0. Outputs during reset: `stall`=1; `branch_en`, flushes, `halt_ack`, `done` all 0; `branch_pc`=0.
- Reset asserted in any state returns to BOOT immediately (asynchronous).
- First `branch_en` occurs `BOOT_CYCLES` cycles after the first rising edge with `rst_n`=1.
- Halt latency: `halt_ack` rises `DRAIN_CYCLES`+1 cycles after `halt_req` is sampled high in RUN, with no branch during the drain. After `halt_req` falls, RUN is entered on the next edge.
- If `halt_req` drops during DRAIN, the drain completes, HALTED lasts one cycle, then RUN.

## Test plan
- Reset release with defaults -> `stall`=1 for 2 cycles, then one cycle of `branch_en`=1, `branch_pc`=0, both flushes=1, then all controls 0.
- In RUN, `ex_mem_read`=1, `ex_rd`=5, `id_rs2`=5, `id_uses_rs2`=1 -> exactly one cycle of `stall`=1 and `flush_idex`=1; `stall_count` increments by 1. Repeat with `ex_rd`=0 -> no stall.
- Taken branch to 64'h58 in the same cycle as a load-use match -> `branch_en`=1, `branch_pc`=64'h58, both flushes=1, `stall`=0.
- `halt_req` pulsed high and held -> `halt_ack`=1 after 4 cycles. Release `halt_req` -> RUN next cycle and `halt_ack`=0. A branch on drain cycle 2 -> `halt_ack` is delayed by 2 further cycles.
- `pc` reaches 64'h168 -> `done`=1 after 4 cycles and `stall` remains 1; asserting `halt_req` has no effect; pulsing `rst_n` low -> BOOT.
- Force `stall_count` to 32'hFFFF_FFFE with stall held -> reaches 32'hFFFF_FFFF and holds.
